cam_init_sequencer: RTL and testbench

Parametrised camera register-initialisation sequencer. It walks an entry table of WRITE, DELAY and END opcodes and issues each register write to the SCCB master over a valid/ready command channel. It waits for the per-write response, retries failed writes and inserts timed delays (for example after a soft reset). It sits between the top-level bring-up control and the SCCB master, ahead of the pixel capture path.

---
 rtl/cam_init_pkg.sv | 55 +++++
 rtl/cam_init_sequencer_if.sv | 22 ++
 rtl/cam_init_rom.sv | 61 ++++++
 rtl/cam_init_sequencer.sv | 132 +++++++++++++
 tb/tb_cam_init_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_init_pkg.sv
// Shared types for the camera init sequencer: table entry layout, opcodes, FSM states.
// Table-building helpers keep ROM contents readable.
package cam_init_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_DELAY = 2'd1,
        OP_END   = 2'd2
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_RSP,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_e;

    function automatic entry_t mk_wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        entry_t e;
        e.op   = OP_WRITE;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    function automatic entry_t mk_dly(input logic [DATA_W-1:0] n);
        entry_t e;
        e.op   = OP_DELAY;
        e.addr = '0;
        e.data = n;
        return e;
    endfunction

    function automatic entry_t mk_end();
        entry_t e;
        e.op   = OP_END;
        e.addr = '0;
        e.data = '0;
        return e;
    endfunction

endpackage

// File: rtl/cam_init_sequencer_if.sv
// Command/response channel between the init sequencer (master) and the SCCB master (slave).
interface cam_init_sequencer_if #(
    parameter int ADDR_W = cam_init_pkg::ADDR_W,
    parameter int DATA_W = cam_init_pkg::DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_err
    );
endinterface

// File: rtl/cam_init_rom.sv
// Register-init table ROM (OV7670 bring-up, or a short test table); 1-clk registered read.
// No backpressure: a new index is looked up every cycle.
module cam_init_rom
    import cam_init_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter bit TEST_ROM = 1'b0
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    output entry_t           entry
);

    // Soft reset needs ~1 ms settle before further writes are accepted.
    function automatic entry_t ov7670_tbl(input int i);
        entry_t e;
        case (i)
            0:       e = mk_wr(8'h12, 8'h80);
            1:       e = mk_dly(8'd10);
            2:       e = mk_wr(8'h11, 8'h01);
            3:       e = mk_wr(8'h12, 8'h04);
            4:       e = mk_wr(8'h0c, 8'h00);
            5:       e = mk_wr(8'h3e, 8'h00);
            6:       e = mk_wr(8'h40, 8'hd0);
            7:       e = mk_wr(8'h3a, 8'h04);
            8:       e = mk_wr(8'h14, 8'h18);
            9:       e = mk_wr(8'h4f, 8'hb3);
            10:      e = mk_wr(8'h50, 8'hb3);
            11:      e = mk_wr(8'h51, 8'h00);
            12:      e = mk_wr(8'h52, 8'h3d);
            13:      e = mk_wr(8'h53, 8'ha7);
            14:      e = mk_wr(8'h54, 8'he4);
            15:      e = mk_wr(8'h58, 8'h9e);
            default: e = mk_end();
        endcase
        return e;
    endfunction

    // Eight entries with no END: exercises the implicit stop at the last index.
    function automatic entry_t test_tbl(input int i);
        entry_t e;
        case (i)
            0:       e = mk_wr(8'h12, 8'h80);
            1:       e = mk_dly(8'd2);
            2:       e = mk_wr(8'h11, 8'h00);
            3:       e = mk_dly(8'd0);
            4:       e = mk_wr(8'h3a, 8'h04);
            5:       e = mk_wr(8'h40, 8'hd0);
            6:       e = mk_wr(8'h8c, 8'h00);
            7:       e = mk_wr(8'h3e, 8'h00);
            default: e = mk_end();
        endcase
        return e;
    endfunction

    always_ff @(posedge clk) begin
        entry <= TEST_ROM ? test_tbl(int'(idx)) : ov7670_tbl(int'(idx));
    end

endmodule

// File: rtl/cam_init_sequencer.sv
// Walks the init table, issuing SCCB writes with retry and timed delays; WRITE >= 4 clks + link latency.
// cmd_valid holds addr/data stable until cmd_ready; responses are only consumed in WAIT_RSP.
module cam_init_sequencer
    import cam_init_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int DELAY_UNIT = 50000,
    parameter int MAX_RETRY  = 3,
    parameter bit TEST_ROM   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    cam_init_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [IDX_W-1:0]     index
);

    localparam int DLY_W = $clog2(DELAY_UNIT * (2**DATA_W - 1) + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state;
    entry_t           rom_entry;
    logic [RTY_W-1:0] retry;
    logic [DLY_W-1:0] dly_cnt;
    logic             adv;

    cam_init_rom #(
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .TEST_ROM (TEST_ROM)
    ) u_rom (
        .clk   (clk),
        .idx   (index),
        .entry (rom_entry)
    );

    assign adv = ((state == S_WAIT_RSP) && bus.rsp_valid && !bus.rsp_err) ||
                 ((state == S_DELAY) && (dly_cnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            index         <= '0;
            retry         <= '0;
            dly_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_addr  <= '0;
            bus.cmd_data  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        retry <= '0;
                        index <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    case (rom_entry.op)
                        OP_WRITE: begin
                            bus.cmd_addr  <= rom_entry.addr;
                            bus.cmd_data  <= rom_entry.data;
                            bus.cmd_valid <= 1'b1;
                            state         <= S_ISSUE;
                        end
                        OP_DELAY: begin
                            dly_cnt <= DLY_W'(rom_entry.data) * DLY_W'(DELAY_UNIT);
                            state   <= S_DELAY;
                        end
                        default: begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        state         <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (bus.rsp_valid && bus.rsp_err) begin
                        if (retry < RTY_MAX) begin
                            retry         <= retry + 1'b1;
                            bus.cmd_valid <= 1'b1;
                            state         <= S_ISSUE;
                        end else begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_ERROR;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_cnt != '0) begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Shared advance: the last table slot ends the run even without an END entry.
            if (adv) begin
                retry <= '0;
                if (index == LAST_IDX) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end else begin
                    index <= index + 1'b1;
                    state <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Directed bench for cam_init_sequencer on the 8-entry test table with a scripted SCCB responder.
module tb_cam_init_sequencer;

    localparam int DEPTH   = 8;
    localparam int IDX_W   = 3;
    localparam int RSP_LAT = 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] index;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int hold_left  = 0;
    int err_left   = 0;
    bit always_err = 1'b0;

    logic [7:0] acc_addr[$];
    logic [7:0] acc_data[$];
    int         acc_cyc[$];

    logic [7:0] exp_a[6] = '{8'h12, 8'h11, 8'h3a, 8'h40, 8'h8c, 8'h3e};
    logic [7:0] exp_d[6] = '{8'h80, 8'h00, 8'h04, 8'hd0, 8'h00, 8'h00};

    cam_init_sequencer_if bus ();

    cam_init_sequencer #(
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .DELAY_UNIT (4),
        .MAX_RETRY  (3),
        .TEST_ROM   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error),
        .index (index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SCCB slave model: optional ready stall, fixed response latency, scripted NACKs.
    initial begin : sccb_model
        int lat;
        lat           = 0;
        bus.cmd_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            bus.rsp_err   = 1'b0;
            if (!rst_n) begin
                lat           = 0;
                bus.cmd_ready = 1'b1;
            end else begin
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        bus.rsp_valid = 1'b1;
                        bus.rsp_err   = always_err || (err_left > 0);
                        if (err_left > 0) err_left--;
                    end
                end
                if (bus.cmd_valid && hold_left > 0) begin
                    bus.cmd_ready = 1'b0;
                    hold_left--;
                end else begin
                    bus.cmd_ready = 1'b1;
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    acc_addr.push_back(bus.cmd_addr);
                    acc_data.push_back(bus.cmd_data);
                    acc_cyc.push_back(cyc);
                    lat = RSP_LAT;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        #2 start = 1'b1;
        @(negedge clk);
        #2 start = 1'b0;
    endtask

    task automatic clear_log();
        acc_addr.delete();
        acc_data.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (!(done || error) && k < budget) begin
            tick(1);
            k++;
        end
        if (!(done || error)) check_val("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_accepts(input int n, input int budget);
        int k;
        k = 0;
        while (acc_addr.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (acc_addr.size() < n) check_val("accept_timeout", acc_addr.size(), n);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        hold_left  = 0;
        err_left   = 0;
        always_err = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic check_replay(input string tag);
        check_val({tag, "_count"}, acc_addr.size(), 6);
        check_val({tag, "_first"}, {acc_addr[0], acc_data[0]}, 16'h1280);
        check_val({tag, "_done"}, done, 1'b1);
    endtask

    initial begin : main
        int stall;
        int bad;
        bit seen_valid;

        // Reset state
        tick(2);
        check_val("rst_cmd_valid", bus.cmd_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_error", error, 1'b0);
        check_val("rst_index", index, 3'd0);
        rst_n = 1'b1;
        tick(1);

        // Nominal run through the whole table (no END), with an ignored start mid-run
        clear_log();
        pulse_start();
        tick(25);
        check_val("mid_busy", busy, 1'b1);
        pulse_start();
        wait_end(400);
        check_val("nom_count", acc_addr.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("nom_addr%0d", i), acc_addr[i], exp_a[i]);
            check_val($sformatf("nom_data%0d", i), acc_data[i], exp_d[i]);
        end
        check_val("gap_delay2", acc_cyc[1] - acc_cyc[0], 17);
        check_val("gap_delay0", acc_cyc[2] - acc_cyc[1], 9);
        check_val("gap_write", acc_cyc[3] - acc_cyc[2], 6);
        check_val("nom_done", done, 1'b1);
        check_val("nom_busy", busy, 1'b0);
        check_val("nom_error", error, 1'b0);
        check_val("nom_index", index, 3'd7);
        check_val("nom_cmd_valid", bus.cmd_valid, 1'b0);

        // Backpressure: ready low for 10 cycles on the first write
        do_reset();
        clear_log();
        hold_left  = 10;
        stall      = 0;
        bad        = 0;
        seen_valid = 1'b0;
        pulse_start();
        for (int k = 0; k < 60 && acc_addr.size() == 0; k++) begin
            tick(1);
            if (bus.cmd_valid) seen_valid = 1'b1;
            else if (seen_valid && acc_addr.size() == 0) bad++;
            if (bus.cmd_valid && !bus.cmd_ready) begin
                stall++;
                if (bus.cmd_addr !== 8'h12 || bus.cmd_data !== 8'h80) bad++;
            end
        end
        check_val("bp_stall_cycles", stall, 10);
        check_val("bp_unstable", bad, 0);
        wait_end(400);
        check_replay("bp");
        check_val("bp_second", acc_addr[1], 8'h11);

        // Two NACKs then success
        do_reset();
        clear_log();
        err_left = 2;
        pulse_start();
        wait_end(400);
        check_val("rty2_count", acc_addr.size(), 8);
        check_val("rty2_issue1", {acc_addr[1], acc_data[1]}, 16'h1280);
        check_val("rty2_issue2", {acc_addr[2], acc_data[2]}, 16'h1280);
        check_val("rty2_next", {acc_addr[3], acc_data[3]}, 16'h1100);
        check_val("rty2_gap", acc_cyc[1] - acc_cyc[0], 4);
        check_val("rty2_done", done, 1'b1);
        check_val("rty2_error", error, 1'b0);

        // Exactly MAX_RETRY NACKs still succeeds
        clear_log();
        err_left = 3;
        pulse_start();
        wait_end(400);
        check_val("rty3_count", acc_addr.size(), 9);
        check_val("rty3_done", done, 1'b1);
        check_val("rty3_error", error, 1'b0);

        // Retries exhausted, then restart clears the error
        clear_log();
        always_err = 1'b1;
        pulse_start();
        wait_end(400);
        check_val("exh_count", acc_addr.size(), 4);
        check_val("exh_error", error, 1'b1);
        check_val("exh_done", done, 1'b0);
        check_val("exh_busy", busy, 1'b0);
        check_val("exh_index", index, 3'd0);
        tick(2);
        always_err = 1'b0;
        clear_log();
        pulse_start();
        check_val("restart_error", error, 1'b0);
        check_val("restart_busy", busy, 1'b1);
        check_val("restart_index", index, 3'd0);
        wait_end(400);
        check_replay("restart");

        // Asynchronous reset while in a DELAY
        clear_log();
        pulse_start();
        wait_accepts(1, 40);
        tick(8);
        check_val("pre_rst_index", index, 3'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rdly_busy", busy, 1'b0);
        check_val("rdly_index", index, 3'd0);
        check_val("rdly_done_err", {done, error}, 2'b00);
        tick(2);
        rst_n = 1'b1;
        clear_log();
        pulse_start();
        wait_end(400);
        check_replay("rdly_replay");

        // Asynchronous reset while a command is stalled in ISSUE
        clear_log();
        hold_left = 6;
        pulse_start();
        tick(3);
        check_val("pre_rst_valid", bus.cmd_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("riss_valid", bus.cmd_valid, 1'b0);
        check_val("riss_busy", busy, 1'b0);
        tick(2);
        rst_n     = 1'b1;
        hold_left = 0;
        clear_log();
        pulse_start();
        wait_end(400);
        check_replay("riss_replay");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
